// File: rtl/dct32_pkg.sv
// Shared constants, row/column coefficient selection and FSM states for the
// 32-point DCT-II odd-part accumulator (dct32_odd_acc).
package dct32_pkg;

    localparam int IN_W_DEF  = 20;
    localparam int ACC_W_DEF = 21;
    localparam int NROW      = 16;

    // Coefficient magnitudes, ordered so that index j corresponds to cos((2j+1)*pi/64).
    localparam int T [NROW] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic       neg;
        logic [3:0] idx;
    } coef_t;

    // Quadrant folding of the phase (2i+1)(2k+1) mod 128; the phase is always odd.
    function automatic coef_t coef_sel(input int i, input int k);
        coef_t r;
        int    m;
        m = ((2 * i + 1) * (2 * k + 1)) % 128;
        if (m < 32) begin
            r.neg = 1'b0;
            r.idx = 4'((m - 1) / 2);
        end else if (m < 64) begin
            r.neg = 1'b1;
            r.idx = 4'((63 - m) / 2);
        end else if (m < 96) begin
            r.neg = 1'b1;
            r.idx = 4'((m - 65) / 2);
        end else begin
            r.neg = 1'b0;
            r.idx = 4'((127 - m) / 2);
        end
        return r;
    endfunction

    // Magnitude of the selected coefficient; lets a lane report its own weight.
    function automatic int coef_mag(input coef_t c);
        return T[c.idx];
    endfunction

endpackage

// File: rtl/dct32_odd_lane.sv
// One odd output row: selects the product for column k, applies its sign and
// accumulates over a 16-beat block.
module dct32_odd_lane
    import dct32_pkg::*;
#(
    parameter int ROW   = 0,
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    accept,
    input  logic [3:0]              k,
    input  logic [15:0][IN_W-1:0]   prod,
    output logic signed [ACC_W-1:0] acc_next
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    logic [IN_W-1:0]         p;
    coef_t                   sel;

    always_comb begin
        sel  = coef_sel(ROW, int'(k));
        p    = prod[sel.idx];
        term = {{(ACC_W - IN_W){p[IN_W-1]}}, p};
        if (sel.neg) begin
            term = -term;
        end
        // Column 0 starts a fresh block, discarding whatever the register holds.
        acc_next = (k == 4'd0) ? term : acc + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/dct32_odd_acc.sv
// Odd-part accumulator of the 32-point DCT-II: 16 beats of constant products in,
// one registered block of y[1], y[3] .. y[31] out. Rounding: DCT32_ODD_ROUND_EN.
module dct32_odd_acc
    import dct32_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       x4,
    input  logic [IN_W-1:0]       x13,
    input  logic [IN_W-1:0]       x22,
    input  logic [IN_W-1:0]       x31,
    input  logic [IN_W-1:0]       x38,
    input  logic [IN_W-1:0]       x46,
    input  logic [IN_W-1:0]       x54,
    input  logic [IN_W-1:0]       x61,
    input  logic [IN_W-1:0]       x67,
    input  logic [IN_W-1:0]       x73,
    input  logic [IN_W-1:0]       x78,
    input  logic [IN_W-1:0]       x82,
    input  logic [IN_W-1:0]       x85,
    input  logic [IN_W-1:0]       x88,
    input  logic [IN_W-1:0]       x90,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*ACC_W-1:0]   y_odd
);

`ifdef DCT32_ODD_ROUND_EN
    localparam int RSH = SHIFT;
`else
    localparam int RSH = 0;
`endif
    localparam int HALF = (1 << RSH) >> 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid is never withdrawn and the payload stays stable until it transfers.
    state_t                  state;
    logic [3:0]              k;
    logic                    accept;
    logic [15:0][IN_W-1:0]   prod;
    logic signed [ACC_W-1:0] lane_next [NROW];
    logic signed [ACC_W-1:0] rsum;
    logic [16*ACC_W-1:0]     fin;

    assign in_ready = (state == ACCUM) || out_ready;
    assign accept   = in_valid && in_ready;

    // Indexed by coefficient-table position; both magnitude-90 entries share x90.
    assign prod = {x4, x13, x22, x31, x38, x46, x54, x61,
                   x67, x73, x78, x82, x85, x88, x90, x90};

    for (genvar g = 0; g < NROW; g++) begin : g_lane
        dct32_odd_lane #(
            .ROW   (g),
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .accept   (accept),
            .k        (k),
            .prod     (prod),
            .acc_next (lane_next[g])
        );
    end

    always_comb begin
        fin  = '0;
        rsum = '0;
        for (int i = 0; i < NROW; i++) begin
            rsum = lane_next[i] + ACC_W'(HALF);
            fin[i*ACC_W +: ACC_W] = rsum >>> RSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            k         <= 4'd0;
            out_valid <= 1'b0;
            y_odd     <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (k == 4'd15) begin
                            y_odd     <= fin;
                            out_valid <= 1'b1;
                            k         <= 4'd0;
                            state     <= HOLD;
                        end else begin
                            k <= k + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    // A beat accepted here is column 0 of the next block (zero bubble).
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                        if (in_valid) begin
                            k <= 4'd1;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_dct32_odd_acc.sv
// Bench for dct32_odd_acc: directed and random blocks against a cosine-derived
// reference matrix, with a scoreboard of expected output blocks.
module tb_dct32_odd_acc;

    localparam int IN_W  = 20;
    localparam int ACC_W = 21;
    localparam int SHIFT = 4;
    localparam int VW    = 16 * ACC_W;
    localparam real PI   = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] x4, x13, x22, x31, x38, x46, x54, x61, x67, x73, x78, x82, x85, x88, x90;
    logic            out_valid;
    logic            out_ready;
    logic [VW-1:0]   y_odd;

    int checks = 0;
    int errors = 0;
    int tmag [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
    int cm [16][16];
    logic [VW-1:0] exp_q [$];
    bit rand_or = 1'b0;

    dct32_odd_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x4(x4), .x13(x13), .x22(x22), .x31(x31), .x38(x38), .x46(x46),
        .x54(x54), .x61(x61), .x67(x67), .x73(x73), .x78(x78), .x82(x82),
        .x85(x85), .x88(x88), .x90(x90),
        .out_valid(out_valid), .out_ready(out_ready), .y_odd(y_odd)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check_int(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] row_of(input logic [VW-1:0] v, input int i);
        logic signed [ACC_W-1:0] r;
        r = v[i*ACC_W +: ACC_W];
        return 64'(r);
    endfunction

    // ---------------- reference model ----------------
    // Coefficient c(n,k) = sign(cos(n(2k+1)pi/64)) * T[j], where j is the table
    // entry whose cosine magnitude matches |cos(n(2k+1)pi/64)|.
    task automatic build_model();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) begin
                real c, a, best_d, d;
                int  best_j;
                c = $cos(PI * real'((2 * i + 1) * (2 * k + 1)) / 64.0);
                a = (c < 0.0) ? -c : c;
                best_j = 0;
                best_d = 10.0;
                for (int j = 0; j < 16; j++) begin
                    d = a - $cos(PI * real'(2 * j + 1) / 64.0);
                    if (d < 0.0) d = -d;
                    if (d < best_d) begin
                        best_d = d;
                        best_j = j;
                    end
                end
                cm[i][k] = (c < 0.0) ? -tmag[best_j] : tmag[best_j];
            end
        end
    endtask

    function automatic longint rnd(input longint s);
`ifdef DCT32_ODD_ROUND_EN
        return (s + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
`else
        return s;
`endif
    endfunction

    function automatic logic [VW-1:0] model(input int xs [16]);
        logic [VW-1:0] v;
        longint s;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            s = 0;
            for (int k = 0; k < 16; k++) s += longint'(cm[i][k]) * longint'(xs[k]);
            v[i*ACC_W +: ACC_W] = ACC_W'(rnd(s));
        end
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input int x);
        in_valid = 1'b1;
        x4  = IN_W'(4 * x);  x13 = IN_W'(13 * x); x22 = IN_W'(22 * x); x31 = IN_W'(31 * x);
        x38 = IN_W'(38 * x); x46 = IN_W'(46 * x); x54 = IN_W'(54 * x); x61 = IN_W'(61 * x);
        x67 = IN_W'(67 * x); x73 = IN_W'(73 * x); x78 = IN_W'(78 * x); x82 = IN_W'(82 * x);
        x85 = IN_W'(85 * x); x88 = IN_W'(88 * x); x90 = IN_W'(90 * x);
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        x4  = IN_W'($urandom); x13 = IN_W'($urandom); x22 = IN_W'($urandom); x31 = IN_W'($urandom);
        x38 = IN_W'($urandom); x46 = IN_W'($urandom); x54 = IN_W'($urandom); x61 = IN_W'($urandom);
        x67 = IN_W'($urandom); x73 = IN_W'($urandom); x78 = IN_W'($urandom); x82 = IN_W'($urandom);
        x85 = IN_W'($urandom); x88 = IN_W'($urandom); x90 = IN_W'($urandom);
    endtask

    // Presents one beat and returns at posedge+1 after it has been accepted.
    task automatic send_beat(input int x);
        bit got;
        got = 1'b0;
        drive_beat(x);
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) got = 1'b1;
        end
        if (!got) check_int("accept_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic send_beats(input int xs [16], input int first, input bit gaps);
        for (int k = first; k < 16; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    drive_idle();
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(xs[k]);
        end
        check_int("latency_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic send_block(input int xs [16], input bit gaps);
        exp_q.push_back(model(xs));
        send_beats(xs, 0, gaps);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check_int("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_int("unexpected_output", 64'd1, 64'd0);
            end else begin
                check_vec("y_odd_block", y_odd, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int xs [16];
        int ys [16];
        build_model();
        rst = 1'b1;
        out_ready = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_out_valid", 64'(out_valid), 64'd0);
        check_vec("reset_y_odd", y_odd, '0);
        check_int("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Impulse X[0] = 1.
        foreach (xs[k]) xs[k] = (k == 0) ? 1 : 0;
        send_block(xs, 1'b0);
        for (int i = 0; i < 16; i++) check_int($sformatf("impulse_row%0d", i), row_of(y_odd, i), rnd(tmag[i]));

        // All ones, then all 511.
        foreach (xs[k]) xs[k] = 1;
        send_block(xs, 1'b0);
        check_int("ones_row0", row_of(y_odd, 0), rnd(922));
        foreach (xs[k]) xs[k] = 511;
        send_block(xs, 1'b0);
        check_int("max_row0", row_of(y_odd, 0), rnd(471142));

        // Negative impulses.
        foreach (xs[k]) xs[k] = (k == 0) ? -512 : 0;
        send_block(xs, 1'b0);
        check_int("neg512_row0", row_of(y_odd, 0), rnd(-46080));
        check_int("neg512_row15", row_of(y_odd, 15), rnd(-2048));
        foreach (xs[k]) xs[k] = (k == 0) ? -1 : 0;
        send_block(xs, 1'b0);
        check_int("neg1_row0", row_of(y_odd, 0), rnd(-90));

        // Output stall for 5 cycles with the next block's first beat waiting.
        foreach (xs[k]) xs[k] = int'($urandom_range(0, 1023)) - 512;
        foreach (ys[k]) ys[k] = int'($urandom_range(0, 1023)) - 512;
        drain();
        out_ready = 1'b0;
        send_block(xs, 1'b1);
        exp_q.push_back(model(ys));
        drive_beat(ys[0]);
        repeat (5) begin
            @(negedge clk);
            check_int("stall_in_ready", 64'(in_ready), 64'd0);
            check_int("stall_out_valid", 64'(out_valid), 64'd1);
            check_vec("stall_y_odd", y_odd, exp_q[0]);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_beat(ys[0]);
        check_int("release_out_valid", 64'(out_valid), 64'd0);
        check_int("release_in_ready", 64'(in_ready), 64'd1);
        send_beats(ys, 1, 1'b1);

        // Random blocks with input gaps and random output back-pressure.
        rand_or = 1'b1;
        repeat (8) begin
            foreach (xs[k]) xs[k] = int'($urandom_range(0, 1023)) - 512;
            send_block(xs, 1'b1);
        end
        rand_or = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Reset after 7 beats of a block, then a clean impulse block.
        for (int k = 0; k < 7; k++) send_beat(int'($urandom_range(0, 1023)) - 512);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_int("midreset_out_valid", 64'(out_valid), 64'd0);
        check_int("midreset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        foreach (xs[k]) xs[k] = (k == 0) ? 1 : 0;
        send_block(xs, 1'b1);
        for (int i = 0; i < 16; i++) check_int($sformatf("post_reset_row%0d", i), row_of(y_odd, i), rnd(tmag[i]));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
